xor16_arbiter: RTL and testbench

XOR16_ARBITER -- requirements
Module: xor16_arbiter

---
 rtl/xor16_arbiter.sv | 75 +++++++
 tb/tb_xor16_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xor16_arbiter.sv
// rtl/xor16_arbiter.sv - two-requester round-robin XOR unit with a one-deep result register
// Optional feature macro: XOR16_ARBITER_PARITY_EN (even parity of the result on p[16]).
module xor16_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v0,
    input  logic             v1,
    input  logic [15:0]      a0,
    input  logic [15:0]      b0,
    input  logic [15:0]      a1,
    input  logic [15:0]      b1,
    output logic             g0,
    output logic             g1,
    output logic [16:0]      p,
    output logic             p_valid,
    output logic             p_id,
    input  logic             p_ready,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state;
    logic        prio;
    logic        free;
    logic        take0;
    logic        take1;
    logic        accept;
    logic [15:0] res;
    logic        par;

    // prio names the requester that wins a tie; it flips to the other side after each grant.
    always_comb begin
        free   = (state == EMPTY) || p_ready;
        take0  = free && v0 && (!v1 || !prio);
        take1  = free && v1 && (!v0 || prio);
        g0     = take0 && !rst;
        g1     = take1 && !rst;
        accept = g0 || g1;
        res    = g1 ? (a1 ^ b1) : (a0 ^ b0);
`ifdef XOR16_ARBITER_PARITY_EN
        par    = ^res;
`else
        par    = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            p        <= '0;
            p_valid  <= 1'b0;
            p_id     <= 1'b0;
            done_cnt <= '0;
            prio     <= 1'b0;
        end else begin
            if (p_valid && p_ready) begin
                done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (accept) begin
                state   <= FULL;
                p       <= {par, res};
                p_id    <= g1;
                p_valid <= 1'b1;
                prio    <= g0;
            end else if (state == FULL && p_ready) begin
                state   <= EMPTY;
                p_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor16_arbiter.sv
// tb/tb_xor16_arbiter.sv - randomized self-checking bench for xor16_arbiter against a behavioural model
module tb_xor16_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, p_ready = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        g0, g1, p_valid, p_id;
    logic [16:0] p;
    logic [7:0]  done_cnt;
    logic        sg0, sg1, sp_valid, sp_id;
    logic [16:0] sp;
    logic [1:0]  sdone;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model state
    bit          m_full;
    logic [15:0] m_p;
    bit          m_id;
    int          m_last;
    int          m_cnt;

    xor16_arbiter dut (
        .clk(clk), .rst(rst), .v0(v0), .v1(v1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .g0(g0), .g1(g1), .p(p), .p_valid(p_valid), .p_id(p_id), .p_ready(p_ready),
        .done_cnt(done_cnt)
    );

    xor16_arbiter #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .v0(v0), .v1(v1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .g0(sg0), .g1(sg1), .p(sp), .p_valid(sp_valid), .p_id(sp_id), .p_ready(p_ready),
        .done_cnt(sdone)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_full = 0;
        m_p    = '0;
        m_id   = 0;
        m_last = 1;
        m_cnt  = 0;
    endfunction

    // Which requester the spec says wins this cycle, or -1 for none.
    function automatic int winner(bit rv0, bit rv1, bit rdy);
        if (m_full && !rdy) return -1;
        if (rv0 && rv1) return (m_last == 0) ? 1 : 0;
        if (rv0) return 0;
        if (rv1) return 1;
        return -1;
    endfunction

    function automatic void model_edge();
        int w;
        bit cons;
        w = winner(v0, v1, p_ready);
        cons = m_full && p_ready;
        if (cons) m_cnt++;
        if (w >= 0) begin
            m_full = 1;
            m_p    = (w == 1) ? (a1 ^ b1) : (a0 ^ b0);
            m_id   = (w == 1);
            m_last = w;
        end else if (cons) begin
            m_full = 0;
        end
    endfunction

    function automatic logic [16:0] exp_p();
`ifdef XOR16_ARBITER_PARITY_EN
        return {^m_p, m_p};
`else
        return {1'b0, m_p};
`endif
    endfunction

    task automatic drive(input bit iv0, input bit iv1, input logic [15:0] ia0, input logic [15:0] ib0,
                         input logic [15:0] ia1, input logic [15:0] ib1, input bit rdy);
        v0 = iv0; v1 = iv1; a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1; p_ready = rdy;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1, 1, 16'h1234, 16'h4321, 16'hAAAA, 16'h5555, 1);
        @(negedge clk);
        #1;
        n_chk++; if (g0 !== 1'b0 || g1 !== 1'b0) begin n_fail++; $display("FAIL reset_grant: g0=%b g1=%b want 0 0", g0, g1); end
        n_chk++; if (p_valid !== 1'b0 || p !== 17'h0 || p_id !== 1'b0) begin n_fail++; $display("FAIL reset_out: p_valid=%b p=%h p_id=%b want 0 0 0", p_valid, p, p_id); end
        n_chk++; if (done_cnt !== 8'd0 || sdone !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: done_cnt=%0d small=%0d want 0 0", done_cnt, sdone); end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        drive(1, 0, 16'h00FF, 16'h0F0F, 16'h0, 16'h0, 1);
        #1;
        n_chk++; if (g0 !== 1'b1 || g1 !== 1'b0) begin n_fail++; $display("FAIL single_grant: g0=%b g1=%b want 1 0", g0, g1); end
        model_edge();
        @(negedge clk);
        n_chk++; if (p[15:0] !== 16'h0FF0 || p_id !== 1'b0 || p_valid !== 1'b1) begin n_fail++; $display("FAIL single_result: p=%h p_id=%b p_valid=%b want 0ff0 0 1", p[15:0], p_id, p_valid); end
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        model_edge();
        @(negedge clk);
        n_chk++; if (done_cnt !== 8'd1 || p_valid !== 1'b0) begin n_fail++; $display("FAIL single_consume: done_cnt=%0d p_valid=%b want 1 0", done_cnt, p_valid); end
    endtask

    task automatic test_contention();
        int order[4] = '{0, 1, 0, 1};
        logic [15:0] x0, y0, x1, y1;
        pulse_reset();
        x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, x0, y0, x1, y1, 1);
            #1;
            n_chk++; if (g0 !== (order[i] == 0) || g1 !== (order[i] == 1)) begin n_fail++; $display("FAIL contention_grant[%0d]: g0=%b g1=%b want requester %0d", i, g0, g1, order[i]); end
            model_edge();
            @(negedge clk);
            n_chk++; if (p_valid !== 1'b1 || p_id !== order[i][0] || p !== exp_p()) begin n_fail++; $display("FAIL contention_result[%0d]: p_valid=%b p_id=%b p=%h want 1 %0d %h", i, p_valid, p_id, p, order[i], exp_p()); end
            if (order[i] == 0) begin x0 = 16'($urandom); y0 = 16'($urandom); end
            else begin x1 = 16'($urandom); y1 = 16'($urandom); end
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        model_edge();
        @(negedge clk);
        n_chk++; if (p_valid !== 1'b0 || done_cnt !== 8'd4) begin n_fail++; $display("FAIL contention_drain: p_valid=%b done_cnt=%0d want 0 4", p_valid, done_cnt); end
    endtask

    task automatic test_backpressure();
        logic [16:0] held_p;
        logic        held_id;
        logic [15:0] x1, y1;
        drive(1, 0, 16'($urandom), 16'($urandom), 0, 0, 0);
        #1;
        n_chk++; if (g0 !== 1'b1) begin n_fail++; $display("FAIL bp_fill_grant: g0=%b want 1", g0); end
        model_edge();
        @(negedge clk);
        held_p = p;
        held_id = p_id;
        n_chk++; if (held_p !== exp_p() || p_valid !== 1'b1) begin n_fail++; $display("FAIL bp_fill: p=%h p_valid=%b want %h 1", held_p, p_valid, exp_p()); end
        x1 = 16'($urandom); y1 = 16'($urandom);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, x1, y1, 0);
            #1;
            n_chk++; if (g0 !== 1'b0 || g1 !== 1'b0) begin n_fail++; $display("FAIL bp_grant[%0d]: g0=%b g1=%b want 0 0", i, g0, g1); end
            model_edge();
            @(negedge clk);
            n_chk++; if (p !== held_p || p_id !== held_id || p_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: p=%h p_id=%b p_valid=%b want %h %b 1", i, p, p_id, p_valid, held_p, held_id); end
        end
        drive(0, 1, 0, 0, x1, y1, 1);
        #1;
        n_chk++; if (g1 !== 1'b1 || g0 !== 1'b0) begin n_fail++; $display("FAIL bp_release_grant: g0=%b g1=%b want 0 1", g0, g1); end
        model_edge();
        @(negedge clk);
        n_chk++; if (p[15:0] !== (x1 ^ y1) || p_id !== 1'b1 || p_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release: p=%h p_id=%b p_valid=%b want %h 1 1", p[15:0], p_id, p_valid, x1 ^ y1); end
        n_chk++; if (done_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL bp_count: done_cnt=%0d want %0d", done_cnt, 8'(m_cnt)); end
    endtask

    task automatic test_mid_reset();
        drive(0, 1, 0, 0, 16'hBEEF, 16'h1111, 1);
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (p_valid !== 1'b0 || p !== 17'h0 || done_cnt !== 8'd0) begin n_fail++; $display("FAIL midreset_async: p_valid=%b p=%h done_cnt=%0d want 0 0 0", p_valid, p, done_cnt); end
        n_chk++; if (g0 !== 1'b0 || g1 !== 1'b0) begin n_fail++; $display("FAIL midreset_grant: g0=%b g1=%b want 0 0", g0, g1); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_chk++; if (g1 !== 1'b1 || g0 !== 1'b0) begin n_fail++; $display("FAIL midreset_v1_grant: g0=%b g1=%b want 0 1", g0, g1); end
        model_edge();
        @(negedge clk);
        n_chk++; if (p_id !== 1'b1 || p_valid !== 1'b1 || p[15:0] !== 16'hAFFE || done_cnt !== 8'd0) begin n_fail++; $display("FAIL midreset_after: p_id=%b p_valid=%b p=%h done_cnt=%0d want 1 1 affe 0", p_id, p_valid, p[15:0], done_cnt); end
    endtask

    task automatic test_parity();
        logic [16:0] want;
`ifdef XOR16_ARBITER_PARITY_EN
        want = 17'h10001;
`else
        want = 17'h00001;
`endif
        drive(1, 0, 16'h0001, 16'h0000, 0, 0, 1);
        #1;
        model_edge();
        @(negedge clk);
        n_chk++; if (p !== want) begin n_fail++; $display("FAIL parity: p=%h want %h", p, want); end
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            drive(i < 5, 0, 16'($urandom), 16'($urandom), 0, 0, 1);
            #1;
            model_edge();
            @(negedge clk);
        end
        n_chk++; if (sdone !== 2'd1 || done_cnt !== 8'd5) begin n_fail++; $display("FAIL wrap: small=%0d wide=%0d want 1 5", sdone, done_cnt); end
    endtask

    task automatic test_random();
        bit hold0 = 0, hold1 = 0;
        bit nv0, nv1;
        logic [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
        int w;
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            nv0 = hold0 ? 1'b1 : 1'($urandom % 2);
            nv1 = hold1 ? 1'b1 : 1'($urandom % 2);
            if (!hold0) begin x0 = 16'($urandom); y0 = 16'($urandom); end
            if (!hold1) begin x1 = 16'($urandom); y1 = 16'($urandom); end
            drive(nv0, nv1, x0, y0, x1, y1, ($urandom % 4) != 0);
            #1;
            w = winner(v0, v1, p_ready);
            n_chk++; if (g0 !== (w == 0) || g1 !== (w == 1)) begin n_fail++; $display("FAIL random_grant[%0d]: g0=%b g1=%b want winner %0d", i, g0, g1, w); end
            hold0 = nv0 && (w != 0);
            hold1 = nv1 && (w != 1);
            model_edge();
            @(negedge clk);
            n_chk++; if (p_valid !== m_full) begin n_fail++; $display("FAIL random_valid[%0d]: p_valid=%b want %b", i, p_valid, m_full); end
            if (m_full) begin
                n_chk++; if (p !== exp_p() || p_id !== m_id) begin n_fail++; $display("FAIL random_result[%0d]: p=%h p_id=%b want %h %b", i, p, p_id, exp_p(), m_id); end
            end
            n_chk++; if (done_cnt !== 8'(m_cnt) || sdone !== 2'(m_cnt)) begin n_fail++; $display("FAIL random_count[%0d]: wide=%0d small=%0d want %0d %0d", i, done_cnt, sdone, 8'(m_cnt), 2'(m_cnt)); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_mid_reset();
        test_parity();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
